// File: rtl/aes_key_expand_rev.sv
// aes_key_expand_rev
// Reverse AES-128 key-schedule generator for the decryption datapath.
// The block is loaded with the final (round 10) round key. Each accepted
// enable steps the schedule back one round, so the inverse cipher can consume
// round keys 10 down to 0 without storing the whole forward schedule.
//
// Ports
//   clk       : single clock, all state updates on the rising edge
//   rst_n     : asynchronous active-low reset
//   kld       : load key_in as the round-10 key and restart the sequence
//   key_in    : round-10 key, w0 in [127:96] ... w3 in [31:0]
//   enable    : step back one round (one step per cycle while high)
//   rkey      : current round key, same word ordering as key_in
//   rnd       : round index of rkey (10 ... 0)
//   rcon      : {rc, 24'h0} consumed by the next backward step, 0 at round 0
//   rkey_vld  : one-cycle pulse, rkey/rnd were updated by the last edge
//   done      : high while rnd == 0 (cipher key present)

// Forward AES S-box, one byte, purely combinational table lookup.
module aes_sbox (
    input  logic [7:0] a,
    output logic [7:0] s
);
    // Entry 0x00 sits in the top byte, so the byte for index a starts at
    // bit (255 - a) * 8, and (255 - a) is simply ~a for an 8-bit index.
    localparam logic [2047:0] SBOX_TBL = {
        128'h637c777bf26b6fc53001672bfed7ab76,
        128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115,
        128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84,
        128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8,
        128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973,
        128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479,
        128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
        128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df,
        128'h8ca1890dbfe6426841992d0fb054bb16
    };

    assign s = SBOX_TBL[{~a, 3'b000} +: 8];
endmodule

module aes_key_expand_rev (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         kld,
    input  logic [127:0] key_in,
    input  logic         enable,
    output logic [127:0] rkey,
    output logic [3:0]   rnd,
    output logic [31:0]  rcon,
    output logic         rkey_vld,
    output logic         done
);
    // Round constant for the step that leaves round r; the reverse of the
    // forward sequence, with zero for round 0 and unused indices.
    function automatic logic [7:0] rc_of(input logic [3:0] r);
        logic [7:0] rc;
        case (r)
            4'd10:   rc = 8'h36;
            4'd9:    rc = 8'h1b;
            4'd8:    rc = 8'h80;
            4'd7:    rc = 8'h40;
            4'd6:    rc = 8'h20;
            4'd5:    rc = 8'h10;
            4'd4:    rc = 8'h08;
            4'd3:    rc = 8'h04;
            4'd2:    rc = 8'h02;
            4'd1:    rc = 8'h01;
            default: rc = 8'h00;
        endcase
        return rc;
    endfunction

    logic [31:0]  w0, w1, w2, w3;
    logic [31:0]  p0, p1, p2, p3;
    logic [31:0]  rot_p3;
    logic [31:0]  sub_p3;
    logic [127:0] prev_key;

    assign w0 = rkey[127:96];
    assign w1 = rkey[95:64];
    assign w2 = rkey[63:32];
    assign w3 = rkey[31:0];

    // Undo the forward XOR chain: each earlier word is the XOR of two
    // adjacent current words. p3 is the previous round's last word, which
    // is what the forward schedule fed through RotWord/SubWord.
    assign p3 = w3 ^ w2;
    assign p2 = w2 ^ w1;
    assign p1 = w1 ^ w0;

    assign rot_p3 = {p3[23:0], p3[31:24]};

    aes_sbox u_sbox3 (.a(rot_p3[31:24]), .s(sub_p3[31:24]));
    aes_sbox u_sbox2 (.a(rot_p3[23:16]), .s(sub_p3[23:16]));
    aes_sbox u_sbox1 (.a(rot_p3[15:8]),  .s(sub_p3[15:8]));
    aes_sbox u_sbox0 (.a(rot_p3[7:0]),   .s(sub_p3[7:0]));

    assign p0       = w0 ^ sub_p3 ^ rcon;
    assign prev_key = {p0, p1, p2, p3};

    assign rcon = {rc_of(rnd), 24'h000000};
    assign done = (rnd == 4'd0);

    // Load wins over a step; at round 0 an enable is ignored, so the
    // sequence parks on the cipher key instead of wrapping.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rkey     <= 128'h0;
            rnd      <= 4'd0;
            rkey_vld <= 1'b0;
        end else if (kld) begin
            rkey     <= key_in;
            rnd      <= 4'd10;
            rkey_vld <= 1'b1;
        end else if (enable && (rnd != 4'd0)) begin
            rkey     <= prev_key;
            rnd      <= rnd - 4'd1;
            rkey_vld <= 1'b1;
        end else begin
            rkey_vld <= 1'b0;
        end
    end
endmodule

// File: tb/tb_aes_key_expand_rev.sv
// Testbench for aes_key_expand_rev. A reference model expands a cipher key
// forward (S-box derived from GF(2^8) inversion plus the affine map) and the
// expected backward sequence is queued as stimulus is issued; a monitor pops
// and compares whenever rkey_vld pulses.
module tb_aes_key_expand_rev;
    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         kld = 1'b0;
    logic         enable = 1'b0;
    logic [127:0] key_in = '0;
    logic [127:0] rkey;
    logic [3:0]   rnd;
    logic [31:0]  rcon;
    logic         rkey_vld;
    logic         done;

    aes_key_expand_rev dut (
        .clk(clk), .rst_n(rst_n), .kld(kld), .key_in(key_in),
        .enable(enable), .rkey(rkey), .rnd(rnd), .rcon(rcon),
        .rkey_vld(rkey_vld), .done(done)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [127:0] key;
        int           r;
        logic [7:0]   rc;
    } exp_t;

    exp_t         q[$];
    int           checks = 0;
    int           failures = 0;
    logic [7:0]   sb[256];
    logic [127:0] sched[11];
    logic [7:0]   rcs[11];
    int           mr = 0;

    function automatic logic [7:0] gmul(input logic [7:0] a_in, input logic [7:0] b_in);
        logic [7:0] a, b, p;
        logic       hi;
        a = a_in; b = b_in; p = 8'h00;
        for (int i = 0; i < 8; i++) begin
            if (b[0]) p = p ^ a;
            hi = a[7];
            a  = a << 1;
            if (hi) a = a ^ 8'h1b;
            b  = b >> 1;
        end
        return p;
    endfunction

    function automatic logic [7:0] rotl8(input logic [7:0] v, input int n);
        return (v << n) | (v >> (8 - n));
    endfunction

    task automatic build_sbox();
        logic [7:0] inv;
        for (int x = 0; x < 256; x++) begin
            inv = 8'h00;
            if (x != 0)
                for (int y = 1; y < 256; y++)
                    if (gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
            sb[x] = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3)
                    ^ rotl8(inv, 4) ^ 8'h63;
        end
    endtask

    function automatic logic [31:0] subword(input logic [31:0] v);
        return {sb[v[31:24]], sb[v[23:16]], sb[v[15:8]], sb[v[7:0]]};
    endfunction

    // Forward AES-128 key expansion; rcs[r] is the constant that produced round r.
    task automatic expand(input logic [127:0] ck);
        logic [31:0] w[44];
        logic [31:0] t;
        logic [7:0]  rc;
        rc = 8'h01;
        for (int i = 0; i < 4; i++) w[i] = ck[127 - 32*i -: 32];
        for (int i = 4; i < 44; i++) begin
            t = w[i-1];
            if (i % 4 == 0) begin
                t = subword({t[23:0], t[31:24]}) ^ {rc, 24'h0};
                rcs[i/4] = rc;
                rc = gmul(rc, 8'h02);
            end
            w[i] = w[i-4] ^ t;
        end
        rcs[0] = 8'h00;
        for (int k = 0; k < 11; k++)
            sched[k] = {w[4*k], w[4*k+1], w[4*k+2], w[4*k+3]};
    endtask

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, req);
        end
    endtask

    function automatic logic [127:0] rand128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    // Drive one cycle of inputs (called at posedge+2), update the model and
    // queue the expected response, then advance to the next posedge+2.
    task automatic cyc(input logic k, input logic e, input logic [127:0] ck);
        exp_t ex;
        if (k) expand(ck);
        kld    = k;
        enable = e;
        key_in = k ? sched[10] : key_in;
        if (k) begin
            mr = 10;
            ex.key = sched[mr]; ex.r = mr; ex.rc = rcs[mr];
            q.push_back(ex);
        end else if (e && mr > 0) begin
            mr--;
            ex.key = sched[mr]; ex.r = mr; ex.rc = rcs[mr];
            q.push_back(ex);
        end
        @(posedge clk);
        #2;
    endtask

    // Scoreboard monitor
    always @(negedge clk) begin
        exp_t ex;
        if (rkey_vld) begin
            if (q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL sb_unexpected_vld actual rnd=%0d rkey=%h required no pulse", rnd, rkey);
            end else begin
                ex = q.pop_front();
                chk("sb_rkey", rkey, ex.key);
                chk("sb_rnd", 128'(rnd), 128'(ex.r));
                chk("sb_rcon", 128'(rcon), 128'({ex.rc, 24'h0}));
                chk("sb_done", 128'(done), 128'(ex.r == 0));
            end
        end
    end

    initial begin
        logic [127:0] ck0, ck1, ck2, ckr;
        logic         kk, ee;

        build_sbox();
        ck0 = 128'h2b7e1516_28aed2a6_abf71588_09cf4f3c;

        repeat (2) @(posedge clk);
        #2;
        chk("rst_rkey", rkey, 128'h0);
        chk("rst_rnd", 128'(rnd), 128'd0);
        chk("rst_done", 128'(done), 128'd1);
        chk("rst_rcon", 128'(rcon), 128'h0);
        chk("rst_vld", 128'(rkey_vld), 128'd0);
        rst_n = 1'b1;
        @(posedge clk);
        #2;

        // Known-answer walk from the FIPS-197 example key
        cyc(1'b1, 1'b0, ck0);
        chk("load_rkey", rkey, 128'hd014f9a8_c9ee2589_e13f0cc8_b6630ca6);
        chk("load_rnd", 128'(rnd), 128'd10);
        chk("load_rcon", 128'(rcon), 128'h36000000);
        chk("load_vld", 128'(rkey_vld), 128'd1);
        cyc(1'b0, 1'b1, ck0);
        chk("step9_rkey", rkey, 128'hac7766f3_19fadc21_28d12941_575c006e);
        chk("step9_rnd", 128'(rnd), 128'd9);
        chk("step9_rcon", 128'(rcon), 128'h1b000000);
        for (int i = 0; i < 8; i++) cyc(1'b0, 1'b1, ck0);
        chk("r1_rkey", rkey, 128'ha0fafe17_88542cb1_23a33939_2a6c7605);
        chk("r1_rnd", 128'(rnd), 128'd1);
        cyc(1'b0, 1'b1, ck0);
        chk("r0_rkey", rkey, ck0);
        chk("r0_done", 128'(done), 128'd1);
        chk("r0_rcon", 128'(rcon), 128'h0);
        for (int i = 0; i < 3; i++) cyc(1'b0, 1'b1, ck0);
        chk("hold_rkey", rkey, ck0);
        chk("hold_rnd", 128'(rnd), 128'd0);
        chk("hold_vld", 128'(rkey_vld), 128'd0);

        // Load beats enable in the same cycle
        ck1 = rand128();
        cyc(1'b1, 1'b0, ck1);
        for (int i = 0; i < 5; i++) cyc(1'b0, 1'b1, ck1);
        chk("prio_pre_rnd", 128'(rnd), 128'd5);
        ck2 = rand128();
        cyc(1'b1, 1'b1, ck2);
        chk("prio_rnd", 128'(rnd), 128'd10);
        chk("prio_rkey", rkey, sched[10]);

        // Asynchronous reset in the middle of a walk
        cyc(1'b0, 1'b1, ck2);
        cyc(1'b0, 1'b1, ck2);
        @(negedge clk);
        #1;
        rst_n  = 1'b0;
        mr     = 0;
        kld    = 1'b0;
        enable = 1'b0;
        #1;
        chk("arst_rkey", rkey, 128'h0);
        chk("arst_rnd", 128'(rnd), 128'd0);
        chk("arst_done", 128'(done), 128'd1);
        chk("arst_rcon", 128'(rcon), 128'h0);
        chk("arst_vld", 128'(rkey_vld), 128'd0);
        repeat (2) @(posedge clk);
        #2;
        rst_n = 1'b1;
        cyc(1'b0, 1'b1, ck2);
        cyc(1'b0, 1'b1, ck2);
        chk("post_rst_rnd", 128'(rnd), 128'd0);

        // Randomised loads and gapped enables
        for (int k = 0; k < 4; k++) begin
            ckr = rand128();
            cyc(1'b1, 1'b0, ckr);
            for (int i = 0; i < 40; i++) begin
                kk = ($urandom % 20) == 0;
                ee = ($urandom % 3) != 0;
                if (kk) ckr = rand128();
                cyc(kk, ee, ckr);
            end
        end
        cyc(1'b0, 1'b0, ck0);
        cyc(1'b0, 1'b0, ck0);

        checks++;
        if (q.size() != 0) begin
            failures++;
            $display("FAIL sb_drain actual pending=%0d required 0", q.size());
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
